// File: rtl/refill_pkg.sv
// refill_pkg: state encoding and default line geometry shared by the refill arbiter files
package refill_pkg;
  localparam int ADDR_W_D = 32;
  localparam int DATA_W_D = 32;
  localparam int LINE_WORDS_D = 4;
  localparam int OFFS_W = $clog2(LINE_WORDS_D * DATA_W_D / 8);
  localparam int BEAT_W = $clog2(LINE_WORDS_D);
  typedef enum logic [2:0] {IDLE, D_WB, D_RD, I_RD, DONE_D, DONE_I} state_t;
endpackage

// File: rtl/refill_beat_ctr.sv
// refill_beat_ctr: burst beat counter (clear/advance) producing beat index, last flag and line-aligned beat address
module refill_beat_ctr
  import refill_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int LINE_WORDS = LINE_WORDS_D
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          advance,
  input  logic [ADDR_W-1:0]             base,
  output logic [$clog2(LINE_WORDS)-1:0] beat,
  output logic                          last,
  output logic [ADDR_W-1:0]             addr
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int OW = $clog2(LINE_WORDS * DATA_W / 8);
  localparam int SW = $clog2(DATA_W / 8);
  logic unused_offs;
  assign unused_offs = ^base[OW-1:0];
  assign last = &beat;
  assign addr = {base[ADDR_W-1:OW], {OW{1'b0}}} + (ADDR_W'(beat) << SW);
  always_ff @(posedge clk)
    beat <= clear ? '0 : advance ? beat + BW'(1) : beat;
endmodule

// File: rtl/refill_arbiter.sv
// refill_arbiter: shares one memory port between I refill and D writeback/refill as locked LINE_WORDS-beat bursts, D first
module refill_arbiter
  import refill_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int LINE_WORDS = LINE_WORDS_D
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic                          d_req,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic                          d_dirty,
  input  logic [ADDR_W-1:0]             d_wb_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          i_wr,
  output logic [$clog2(LINE_WORDS)-1:0] i_beat,
  output logic                          d_wr,
  output logic [$clog2(LINE_WORDS)-1:0] d_beat,
  output logic                          f_arrival,
  output logic                          m_arrival
);
  state_t state, next;
  logic [$clog2(LINE_WORDS)-1:0] beat;
  logic last, done;
  logic [ADDR_W-1:0] base, beat_addr;
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign base = state == D_WB ? d_wb_addr : state == I_RD ? i_addr : d_addr;
  assign done = mem_req && mem_ready && last;
  refill_beat_ctr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) u_ctr (
    .clk(clk),
    .clear(rst || state == IDLE),
    .advance(mem_req && mem_ready),
    .base(base),
    .beat(beat),
    .last(last),
    .addr(beat_addr)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = d_req ? (d_dirty ? D_WB : D_RD) : i_req ? I_RD : IDLE;
      D_WB:    next = done ? D_RD : D_WB;
      D_RD:    next = done ? DONE_D : D_RD;
      I_RD:    next = done ? DONE_I : I_RD;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    mem_req = state == D_WB || state == D_RD || state == I_RD;
    mem_we = state == D_WB;
    mem_addr = mem_req ? beat_addr : '0;
    mem_wdata = mem_we ? d_wdata : '0;
    i_wr = state == I_RD && mem_ready;
    d_wr = state == D_RD && mem_ready;
    i_beat = state == I_RD ? beat : '0;
    d_beat = state == D_WB || state == D_RD ? beat : '0;
    f_arrival = state == DONE_I;
    m_arrival = state == DONE_D;
  end
endmodule

// File: tb/tb_refill_arbiter.sv
// tb_refill_arbiter: transaction-queue model checked every cycle plus hand-computed directed expectations
module tb_refill_arbiter;
  logic clk = 0, rst = 1;
  logic i_req = 0, d_req = 0, d_dirty = 0, mem_ready = 1;
  logic [31:0] i_addr = 0, d_addr = 0, d_wb_addr = 0, d_wdata, mem_rdata = 32'h5555_AAAA;
  logic mem_req, mem_we, i_wr, d_wr, f_arrival, m_arrival;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0] i_beat, d_beat;
  logic [31:0] wb_line [4];
  int checks = 0, errors = 0;

  typedef struct {bit arr; bit we; bit side; logic [31:0] addr; int idx;} rec_t;
  rec_t q[$];

  always #5 clk = ~clk;
  assign d_wdata = wb_line[d_beat];

  refill_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
    .d_dirty(d_dirty), .d_wb_addr(d_wb_addr), .d_wdata(d_wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .i_wr(i_wr), .i_beat(i_beat), .d_wr(d_wr), .d_beat(d_beat),
    .f_arrival(f_arrival), .m_arrival(m_arrival)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push_line(input bit we, input bit side, input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      q.push_back('{arr: 1'b0, we: we, side: side, addr: (a & ~32'hF) + 32'(4 * k), idx: k});
  endtask

  always @(negedge clk) begin
    rec_t r;
    logic e_req, e_we, e_iwr, e_dwr, e_f, e_m;
    logic [31:0] e_addr, e_wdata, e_ib, e_db;
    {e_req, e_we, e_iwr, e_dwr, e_f, e_m} = '0;
    {e_addr, e_wdata, e_ib, e_db} = '0;
    if (rst) q.delete();
    else begin
      if (q.size() > 0) begin
        r = q[0];
        if (r.arr) begin
          e_m = r.side;
          e_f = !r.side;
        end else begin
          e_req = 1;
          e_we = r.we;
          e_addr = r.addr;
          e_wdata = r.we ? wb_line[r.idx] : 32'h0;
          if (r.side) e_db = 32'(r.idx); else e_ib = 32'(r.idx);
          e_dwr = r.side && !r.we && mem_ready;
          e_iwr = !r.side && mem_ready;
        end
      end
      chk("cyc_mem_req", 32'(mem_req), 32'(e_req));
      chk("cyc_mem_we", 32'(mem_we), 32'(e_we));
      chk("cyc_mem_addr", mem_addr, e_addr);
      chk("cyc_mem_wdata", mem_wdata, e_wdata);
      chk("cyc_i_wr", 32'(i_wr), 32'(e_iwr));
      chk("cyc_d_wr", 32'(d_wr), 32'(e_dwr));
      chk("cyc_i_beat", 32'(i_beat), e_ib);
      chk("cyc_d_beat", 32'(d_beat), e_db);
      chk("cyc_f_arrival", 32'(f_arrival), 32'(e_f));
      chk("cyc_m_arrival", 32'(m_arrival), 32'(e_m));
      if (q.size() > 0) begin
        if (q[0].arr || mem_ready) void'(q.pop_front());
      end else if (d_req) begin
        if (d_dirty) push_line(1, 1, d_wb_addr);
        push_line(0, 1, d_addr);
        q.push_back('{arr: 1'b1, we: 1'b0, side: 1'b1, addr: 32'h0, idx: 0});
      end else if (i_req) begin
        push_line(0, 0, i_addr);
        q.push_back('{arr: 1'b1, we: 1'b0, side: 1'b0, addr: 32'h0, idx: 0});
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string name);
    chk(name, {mem_req, mem_we, i_wr, d_wr, f_arrival, m_arrival, i_beat, d_beat}, 32'h0);
    chk({name, "_addr"}, mem_addr, 32'h0);
  endtask

  initial begin
    logic pat [7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    for (int k = 0; k < 4; k++) wb_line[k] = 32'hC0DE_0000 | 32'(k);
    repeat (3) step;
    idle_check("reset_outputs");
    rst = 0;
    step;
    idle_check("idle_after_reset");

    i_req = 1; i_addr = 32'h1004;
    for (int c = 1; c <= 4; c++) begin
      step;
      chk("t1_addr", mem_addr, 32'h1000 + 32'(4 * (c - 1)));
      chk("t1_i_wr", 32'(i_wr), 1);
      chk("t1_f_low", 32'(f_arrival), 0);
    end
    step;
    chk("t1_f_arrival", 32'(f_arrival), 1);
    i_req = 0;
    step;
    chk("t1_f_pulse_end", 32'(f_arrival), 0);
    step;

    i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000;
    for (int c = 1; c <= 4; c++) begin
      step;
      chk("t2_d_addr", mem_addr, 32'h2000 + 32'(4 * (c - 1)));
      chk("t2_d_wr", 32'(d_wr), 1);
    end
    step;
    chk("t2_m_arrival", 32'(m_arrival), 1);
    d_req = 0;
    step;
    chk("t2_idle_gap", 32'(mem_req), 0);
    for (int c = 7; c <= 10; c++) begin
      step;
      chk("t2_i_addr", mem_addr, 32'h1000 + 32'(4 * (c - 7)));
    end
    step;
    chk("t2_f_arrival", 32'(f_arrival), 1);
    i_req = 0;
    step;

    d_req = 1; d_dirty = 1; d_wb_addr = 32'h3008; d_addr = 32'h4000;
    for (int c = 1; c <= 4; c++) begin
      step;
      chk("t3_wb_we", 32'(mem_we), 1);
      chk("t3_wb_addr", mem_addr, 32'h3000 + 32'(4 * (c - 1)));
      chk("t3_wb_data", mem_wdata, 32'hC0DE_0000 | 32'(c - 1));
    end
    for (int c = 5; c <= 8; c++) begin
      step;
      chk("t3_rd_we", 32'(mem_we), 0);
      chk("t3_rd_addr", mem_addr, 32'h4000 + 32'(4 * (c - 5)));
    end
    step;
    chk("t3_m_arrival", 32'(m_arrival), 1);
    d_req = 0; d_dirty = 0;
    step;

    i_req = 1; i_addr = 32'h5000;
    begin
      logic [31:0] exp_a [7];
      exp_a = '{32'h5000, 32'h5004, 32'h5004, 32'h5004, 32'h5008, 32'h500C, 32'h500C};
      for (int c = 0; c < 7; c++) begin
        step;
        mem_ready = pat[c];
        #1;
        chk("t4_addr", mem_addr, exp_a[c]);
        chk("t4_i_wr", 32'(i_wr), 32'(pat[c]));
        chk("t4_f_low", 32'(f_arrival), 0);
      end
    end
    step;
    mem_ready = 1;
    chk("t4_f_arrival", 32'(f_arrival), 1);
    i_req = 0;
    step;

    d_req = 1; d_addr = 32'h6000;
    step;
    step;
    chk("t5_beat1", mem_addr, 32'h6004);
    step;
    rst = 1;
    chk("t5_rst_cycle_m", 32'(m_arrival), 0);
    step;
    idle_check("t5_after_rst");
    rst = 0; d_addr = 32'h7000;
    step;
    chk("t5_fresh_addr", mem_addr, 32'h7000);
    chk("t5_fresh_beat", 32'(d_beat), 0);
    begin
      int budget = 20;
      while (!m_arrival && budget > 0) begin
        step;
        budget--;
      end
      chk("t5_arrival_seen", 32'(m_arrival), 1);
    end
    d_req = 0;
    repeat (3) step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
